word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-to-serial reader for latched data words. It accepts one WORD_LENGTH-bit word through a valid/ready load handshake, then shifts it out one bit per enabled cycle with frame markers. It is the consumer of the parallel register path. It drains a latched word onto a single-bit link for the downstream decoder chain.

## Interface
- WORD_LENGTH, 5: bits per word; minimum 2.
- MSB_FIRST, 1: 1 sends bit WORD_LENGTH-1 first; 0 sends bit 0 first.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- Data_Input  input  WORD_LENGTH  word to serialize; sampled only on an accepting edge.
- Load_Valid  input  1  producer offers Data_Input.
- Load_Ready  output  1  serializer can accept a word this cycle (combinational).
- Shift_Enable  input  1  link tick; a bit is consumed only on cycles where it is 1.
- Serial_Output  output  1  current bit on the link (registered).
- Bit_Valid  output  1  Serial_Output is valid and consumed this cycle.
- Frame_Start  output  1  first bit of a word is on the link.
- Frame_End  output  1  last bit of a word is on the link.
- Busy  output  1  a word is in flight (state SHIFT).

## Operation
- The design has two states:
  - IDLE: no word in flight.
  - SHIFT: a word is in flight.
- The design has four registers:
  - shift_reg: WORD_LENGTH bits.
  - bit_cnt: width is clog2(WORD_LENGTH), counting 0..WORD_LENGTH-1.
  - state.
  - Serial_Output, taken from the current head of shift_reg.
- Accept condition: the accept condition is Load_Valid && Load_Ready.
- Load_Ready is 1 in either of these cases:
  - state==IDLE.
  - state==SHIFT && bit_cnt==WORD_LENGTH-1 && Shift_Enable (last bit being consumed). This gives back-to-back frames with no gap.
- IDLE, accept:
  - shift_reg<=Data_Input, bit_cnt<=0, state<=SHIFT.
- IDLE, no accept:
  - Hold all state.
  - Serial_Output is 0.
- SHIFT, Shift_Enable=0:
  - Hold shift_reg, bit_cnt and Serial_Output.
  - Bit_Valid=0.
- SHIFT, Shift_Enable=1, bit_cnt<WORD_LENGTH-1:
  - Advance shift_reg one position (left if MSB_FIRST, else right, zero fill).
  - bit_cnt<=bit_cnt+1.
- SHIFT, Shift_Enable=1, bit_cnt==WORD_LENGTH-1, with accept:
  - Reload shift_reg, bit_cnt<=0, stay in SHIFT.
- SHIFT, Shift_Enable=1, bit_cnt==WORD_LENGTH-1, without accept:
  - state<=IDLE.
- Output definitions:
  - Bit_Valid = Busy && Shift_Enable.
  - Frame_Start = Busy && bit_cnt==0.
  - Frame_End = Busy && bit_cnt==WORD_LENGTH-1.
  - Busy = state==SHIFT.
  - Serial_Output = head bit of shift_reg when Busy, else 0.
- Data_Input changes while Busy have no effect on the word in flight.
- Load_Valid held with Load_Ready=0 is not consumed. The producer must hold Data_Input until the accepting edge.

## Timing
- Reset: reset=1 at a rising edge forces the following:
  - state=IDLE, shift_reg=0, bit_cnt=0.
  - Outputs after that edge: Serial_Output=0, Busy=0, Bit_Valid=0, Frame_Start=0, Frame_End=0, Load_Ready=1.
- Reset mid-frame aborts the word; no partial bits follow.
- reset has priority over an accept on the same edge.
- Latency: the first bit appears on Serial_Output in the cycle after the accepting edge, with Frame_Start=1.
- With Shift_Enable held at 1, a frame occupies exactly WORD_LENGTH cycles.
- Continuous streaming: with Load_Valid and Shift_Enable held at 1, throughput is 1 bit/cycle and Busy never drops.
- Stall: each Shift_Enable=0 cycle extends the frame by exactly one cycle. The bit stays stable on Serial_Output during the stall.
- Frame_Start and Frame_End are level flags and may span stall cycles.
- The consumer must qualify them with Bit_Valid.

## Test plan
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then reset=0 with all inputs 0.
  - Required response: Load_Ready=1, Busy=0, Serial_Output=0 for 10 cycles.
- Single word, MSB first, WORD_LENGTH=5:
  - Stimulus: Data_Input=5'b10110, Load_Valid pulsed for 1 cycle, Shift_Enable=1.
  - Required response: the next 5 cycles show Serial_Output=1,0,1,1,0 with Bit_Valid=1.
  - Frame_Start is 1 on the first bit only; Frame_End is 1 on the fifth only.
  - Busy=0 on the sixth cycle.
- LSB first:
  - Stimulus: MSB_FIRST=0, Data_Input=5'b10110.
  - Required response: Serial_Output=0,1,1,0,1.
- Stall:
  - Stimulus: 5'b11001 with Shift_Enable=0 for 3 cycles after the second bit.
  - Required response: Serial_Output holds 1 with Bit_Valid=0 during the stall.
  - Frame completes after 8 total cycles; the bit sequence is unchanged.
- Back-to-back:
  - Stimulus: Load_Valid=1 continuously with 5'b10000, then 5'b00001.
  - Required response: 10 consecutive valid bits 1,0,0,0,0,0,0,0,0,1.
  - Load_Ready=1 on cycle 5; Busy stays 1 throughout.
- Reset mid-frame:
  - Stimulus: reset=1 on the third bit of 5'b11111.
  - Required response: next cycle Busy=0, Serial_Output=0, Load_Ready=1.
  - A subsequent word 5'b01010 serializes correctly from bit 0.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer: valid/ready loaded parallel-to-serial shifter with frame markers.
module word_serializer #(
    parameter int WORD_LENGTH = 5,
    parameter bit MSB_FIRST   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] Data_Input,
    input  logic                   Load_Valid,
    output logic                   Load_Ready,
    input  logic                   Shift_Enable,
    output logic                   Serial_Output,
    output logic                   Bit_Valid,
    output logic                   Frame_Start,
    output logic                   Frame_End,
    output logic                   Busy
);
    localparam int CW = $clog2(WORD_LENGTH);
    localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t                 r_state;
    logic [WORD_LENGTH-1:0] r_shift;
    logic [CW-1:0]          r_cnt;
    logic                   r_serial;
    logic [WORD_LENGTH-1:0] w_shifted;
    logic                   w_last;
    logic                   w_accept;
    assign w_shifted     = MSB_FIRST ? {r_shift[WORD_LENGTH-2:0], 1'b0} : {1'b0, r_shift[WORD_LENGTH-1:1]};
    assign Busy          = r_state == SHIFT;
    assign w_last        = Busy && r_cnt == LAST && Shift_Enable;
    assign Load_Ready    = !Busy || w_last;
    assign w_accept      = Load_Valid && Load_Ready;
    assign Bit_Valid     = Busy && Shift_Enable;
    assign Frame_Start   = Busy && r_cnt == '0;
    assign Frame_End     = Busy && r_cnt == LAST;
    assign Serial_Output = r_serial;
    // r_serial always carries the head of the next shift_reg value so the bit is on the link the cycle after each edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_serial <= 1'b0;
        end else if (w_accept) begin
            r_state  <= SHIFT;
            r_shift  <= Data_Input;
            r_cnt    <= '0;
            r_serial <= MSB_FIRST ? Data_Input[WORD_LENGTH-1] : Data_Input[0];
        end else if (w_last) begin
            r_state  <= IDLE;
            r_serial <= 1'b0;
        end else if (Bit_Valid) begin
            r_shift  <= w_shifted;
            r_cnt    <= r_cnt + 1'b1;
            r_serial <= MSB_FIRST ? w_shifted[WORD_LENGTH-1] : w_shifted[0];
        end
    end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed checks of an MSB-first and an LSB-first serializer on shared stimulus.
module tb_word_serializer;
    logic       clk = 0;
    logic       reset = 1;
    logic [4:0] Data_Input = '0;
    logic       Load_Valid = 0;
    logic       Shift_Enable = 0;
    logic       m_ready, m_ser, m_bv, m_fs, m_fe, m_busy;
    logic       l_ready, l_ser, l_bv, l_fs, l_fe, l_busy;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    word_serializer #(.WORD_LENGTH(5), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .Data_Input(Data_Input), .Load_Valid(Load_Valid),
        .Load_Ready(m_ready), .Shift_Enable(Shift_Enable), .Serial_Output(m_ser),
        .Bit_Valid(m_bv), .Frame_Start(m_fs), .Frame_End(m_fe), .Busy(m_busy)
    );

    word_serializer #(.WORD_LENGTH(5), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .Data_Input(Data_Input), .Load_Valid(Load_Valid),
        .Load_Ready(l_ready), .Shift_Enable(Shift_Enable), .Serial_Output(l_ser),
        .Bit_Valid(l_bv), .Frame_Start(l_fs), .Frame_End(l_fe), .Busy(l_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads w, then walks its five bits; stall_n disabled cycles are inserted on bit stall_bit.
    task automatic send(input logic [4:0] w, input int stall_bit, input int stall_n, input bit lsb);
        logic exp;
        Data_Input   = w;
        Load_Valid   = 1;
        Shift_Enable = 1;
        tick();
        Load_Valid = 0;
        Data_Input = ~w;
        for (int b = 0; b < 5; b++) begin
            exp = lsb ? w[b] : w[4-b];
            if (b == stall_bit) begin
                for (int s = 0; s < stall_n; s++) begin
                    Shift_Enable = 0;
                    #1;
                    chk("stall_ser", lsb ? l_ser : m_ser, exp);
                    chk("stall_bv", lsb ? l_bv : m_bv, 0);
                    chk("stall_busy", lsb ? l_busy : m_busy, 1);
                    tick();
                end
            end
            Shift_Enable = 1;
            #1;
            chk("ser", lsb ? l_ser : m_ser, exp);
            chk("bv", lsb ? l_bv : m_bv, 1);
            chk("fs", lsb ? l_fs : m_fs, b == 0);
            chk("fe", lsb ? l_fe : m_fe, b == 4);
            tick();
        end
        Shift_Enable = 0;
        #1;
        chk("done_busy", lsb ? l_busy : m_busy, 0);
        chk("done_ser", lsb ? l_ser : m_ser, 0);
        chk("done_ready", lsb ? l_ready : m_ready, 1);
    endtask

    initial begin
        logic [9:0] stream;
        tick();
        tick();
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_ready", m_ready, 1);
            chk("idle_busy", m_busy, 0);
            chk("idle_ser", m_ser, 0);
            tick();
        end
        send(5'b10110, -1, 0, 0);
        send(5'b10110, -1, 0, 1);
        send(5'b11001, 1, 3, 0);
        // back-to-back: 10000 then 00001 streamed with no gap
        stream       = 10'b1000000001;
        Data_Input   = 5'b10000;
        Load_Valid   = 1;
        Shift_Enable = 1;
        tick();
        Data_Input = 5'b00001;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) Load_Valid = 0;
            #1;
            chk("b2b_ser", m_ser, stream[9-i]);
            chk("b2b_bv", m_bv, 1);
            chk("b2b_busy", m_busy, 1);
            if (i == 4) chk("b2b_ready", m_ready, 1);
            if (i == 3) chk("b2b_notready", m_ready, 0);
            tick();
        end
        Shift_Enable = 0;
        #1;
        chk("b2b_end_busy", m_busy, 0);
        // reset mid-frame on the third bit
        Data_Input   = 5'b11111;
        Load_Valid   = 1;
        Shift_Enable = 1;
        tick();
        Load_Valid = 0;
        tick();
        tick();
        #1;
        chk("mid_third_ser", m_ser, 1);
        reset = 1;
        tick();
        reset        = 0;
        Shift_Enable = 0;
        #1;
        chk("mid_busy", m_busy, 0);
        chk("mid_ser", m_ser, 0);
        chk("mid_ready", m_ready, 1);
        chk("mid_fs", m_fs, 0);
        send(5'b01010, -1, 0, 0);
        // reset wins over a simultaneous accept
        Data_Input = 5'b10101;
        Load_Valid = 1;
        reset      = 1;
        tick();
        reset      = 0;
        Load_Valid = 0;
        #1;
        chk("rst_prio_busy", m_busy, 0);
        chk("rst_prio_ser", m_ser, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
